// File: rtl/shift_ctrl.sv
// Command sequencer for an N-bit shift register: expands clear/load/multi-bit shift
// commands into per-cycle ctrl codes and returns the register contents afterwards.
module shift_ctrl #(
    parameter int N  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_amt,
    input  logic [N-1:0]  cmd_data,
    output logic [2:0]    sr_ctrl,
    output logic [N-1:0]  sr_in,
    input  logic [N-1:0]  sr_out,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [N-1:0]  rsp_data,
    output logic          busy
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_e;

    typedef enum logic [2:0] {
        SR_CLEAR = 3'd0,
        SR_LOAD  = 3'd1,
        SR_SHR   = 3'd2,
        SR_SHL   = 3'd3,
        SR_HOLD  = 3'd4
    } sr_ctrl_e;

    state_e          state_q;
    sr_ctrl_e        sr_ctrl_q;
    logic [N-1:0]    sr_in_q;
    logic [N-1:0]    rsp_data_q;
    logic            rsp_valid_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   steps_d;

    // Shifts of N or more saturate at N single-bit steps, which leaves the register at zero.
    always_comb begin
        steps_d = CW'(1);
        if (cmd_op == 2'd2 || cmd_op == 2'd3) begin
            if (int'(cmd_amt) >= N) steps_d = CW'(N);
            else                    steps_d = CW'(cmd_amt);
        end
    end

    // NOTE: state and outputs are updated with non-blocking assignments so every
    // register samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_ctrl_q   <= SR_HOLD;
            sr_in_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_op == 2'd1) sr_in_q <= cmd_data;
                        cnt_q <= steps_d;
                        if (steps_d == '0) begin
                            state_q <= CAPT;
                        end else begin
                            state_q   <= EXEC;
                            sr_ctrl_q <= sr_ctrl_e'({1'b0, cmd_op});
                        end
                    end
                end
                EXEC: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        sr_ctrl_q <= SR_HOLD;
                        state_q   <= CAPT;
                    end
                end
                CAPT: begin
                    rsp_data_q  <= sr_out;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign sr_ctrl   = sr_ctrl_q;
    assign sr_in     = sr_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Self-checking bench for shift_ctrl: directed vector table, hand-written corner
// sequences, and random commands compared against a behavioural result model.
module tb_shift_ctrl;

    localparam int N      = 8;
    localparam int AW     = 4;
    localparam int BUDGET = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_amt;
    logic [N-1:0]  cmd_data;
    logic [2:0]    sr_ctrl;
    logic [N-1:0]  sr_in;
    logic [N-1:0]  sr_out;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  rsp_data;
    logic          busy;

    always #5 clk = ~clk;

    shift_ctrl #(.N(N), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .cmd_data  (cmd_data),
        .sr_ctrl   (sr_ctrl),
        .sr_in     (sr_in),
        .sr_out    (sr_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // The controlled shift register; deliberately not reset by rst.
    logic [N-1:0] sr_q = '0;
    always @(posedge clk) begin
        case (sr_ctrl)
            3'd0:    sr_q <= '0;
            3'd1:    sr_q <= sr_in;
            3'd2:    sr_q <= sr_q >> 1;
            3'd3:    sr_q <= sr_q << 1;
            default: sr_q <= sr_q;
        endcase
    end
    assign sr_out = sr_q;

    int n_checks = 0;
    int n_errors = 0;
    logic [N-1:0] model_q = '0;

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] amt;
        logic [N-1:0]  data;
        logic [N-1:0]  exp_data;
        int            exp_steps;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] model_result(input logic [1:0] op, input int amt,
                                                  input logic [N-1:0] data, input logic [N-1:0] cur);
        case (op)
            2'd0:    return '0;
            2'd1:    return data;
            2'd2:    return (amt >= N) ? '0 : cur >> amt;
            default: return (amt >= N) ? '0 : cur << amt;
        endcase
    endfunction

    function automatic int model_steps(input logic [1:0] op, input int amt);
        if (op < 2'd2) return 1;
        return (amt < N) ? amt : N;
    endfunction

    // Waits (bounded) for the acceptance edge; returns just after it.
    task automatic accept(output bit ok);
        bit rdy;
        ok = 1'b0;
        for (int c = 0; c < BUDGET && !ok; c++) begin
            rdy = cmd_ready;
            @(posedge clk); #1;
            if (rdy) ok = 1'b1;
        end
    endtask

    // Starting just after the acceptance edge, counts ctrl cycles until rsp_valid.
    task automatic track(input logic [1:0] op, output int lat, output int ncyc, output int nbad);
        lat = -1; ncyc = 0; nbad = 0;
        for (int k = 0; k < BUDGET; k++) begin
            if (rsp_valid) begin
                lat = k;
                break;
            end
            if (sr_ctrl == {1'b0, op}) ncyc++;
            else if (sr_ctrl != 3'd4)  nbad++;
            @(posedge clk); #1;
        end
    endtask

    task automatic finish_rsp(input int hold, input logic [N-1:0] exp, input string name);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            @(posedge clk); #1;
            check({name, " held rsp"}, {rsp_valid, cmd_ready, rsp_data}, {1'b1, 1'b0, exp});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({name, " rsp released"}, {rsp_valid, cmd_ready, busy}, 3'b010);
    endtask

    task automatic run_cmd(input logic [1:0] op, input int amt, input logic [N-1:0] data,
                           input int hold, input logic [N-1:0] exp, input int steps, input string name);
        bit ok;
        int lat, ncyc, nbad;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = AW'(amt);
        cmd_data  = data;
        accept(ok);
        cmd_valid = 1'b0;
        check({name, " accepted"}, 32'(ok), 1);
        if (!ok) return;
        track(op, lat, ncyc, nbad);
        check({name, " latency"}, lat, steps + 1);
        check({name, " ctrl cycles"}, ncyc, steps);
        check({name, " stray ctrl"}, nbad, 0);
        if (lat < 0) return;
        check({name, " rsp_data"}, rsp_data, exp);
        finish_rsp(hold, exp, name);
    endtask

    initial begin
        bit ok;
        int lat, ncyc, nbad;
        logic [1:0]   r_op;
        int           r_amt;
        logic [N-1:0] r_data, r_exp;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_amt = '0; cmd_data = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", {cmd_ready, busy, rsp_valid, sr_ctrl, sr_in, rsp_data},
              {1'b1, 1'b0, 1'b0, 3'd4, 8'h00, 8'h00});
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle after reset", {cmd_ready, busy}, 2'b10);

        vecs[0] = '{2'd1, 4'd0,  8'hA5, 8'hA5, 1};
        vecs[1] = '{2'd2, 4'd3,  8'h00, 8'h14, 3};
        vecs[2] = '{2'd3, 4'd2,  8'h00, 8'h50, 2};
        vecs[3] = '{2'd1, 4'd0,  8'hFF, 8'hFF, 1};
        vecs[4] = '{2'd3, 4'd15, 8'h00, 8'h00, 8};
        vecs[5] = '{2'd1, 4'd0,  8'h3C, 8'h3C, 1};
        vecs[6] = '{2'd2, 4'd0,  8'hEE, 8'h3C, 0};
        vecs[7] = '{2'd0, 4'd5,  8'h77, 8'h00, 1};
        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].op, int'(vecs[i].amt), vecs[i].data, i % 3,
                    vecs[i].exp_data, vecs[i].exp_steps, $sformatf("vec%0d", i));
            model_q = vecs[i].exp_data;
        end

        // Backpressure: response held for 5 cycles while the next command waits.
        run_cmd(2'd1, 0, 8'h96, 0, 8'h96, 1, "bp load");
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_amt = AW'(1);
        accept(ok);
        check("bp shr accepted", 32'(ok), 1);
        cmd_op = 2'd1; cmd_data = 8'h5A;
        track(2'd2, lat, ncyc, nbad);
        check("bp shr latency", lat, 2);
        for (int h = 0; h < 5; h++) begin
            @(posedge clk); #1;
            check("bp hold", {rsp_valid, cmd_ready, rsp_data}, {1'b1, 1'b0, 8'h4B});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp idle after handshake", {rsp_valid, cmd_ready}, 2'b01);
        @(posedge clk); #1;
        check("bp queued accepted", {busy, sr_ctrl}, {1'b1, 3'd1});
        cmd_valid = 1'b0;
        track(2'd1, lat, ncyc, nbad);
        check("bp queued latency", lat, 2);
        check("bp queued data", rsp_data, 8'h5A);
        finish_rsp(0, 8'h5A, "bp queued");

        // Reset in the middle of a 6-step shift after two steps have executed.
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_amt = AW'(6);
        accept(ok);
        cmd_valid = 1'b0;
        check("rst cmd accepted", 32'(ok), 1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("rst mid-exec", {sr_ctrl, rsp_valid, busy, cmd_ready}, {3'd4, 1'b0, 1'b0, 1'b1});
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("rst no rsp", {rsp_valid, busy, sr_ctrl}, {1'b0, 1'b0, 3'd4});
        end
        check("rst partial shifts", sr_out, 8'h16);
        run_cmd(2'd1, 0, 8'h81, 1, 8'h81, 1, "post-rst load");
        model_q = 8'h81;

        for (int i = 0; i < 40; i++) begin
            r_op   = 2'($urandom_range(0, 3));
            r_amt  = int'($urandom_range(0, 15));
            r_data = N'($urandom);
            r_exp  = model_result(r_op, r_amt, r_data, model_q);
            run_cmd(r_op, r_amt, r_data, int'($urandom_range(0, 3)), r_exp,
                    model_steps(r_op, r_amt), $sformatf("rand%0d op%0d amt%0d", i, r_op, r_amt));
            model_q = r_exp;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_ctrl.md
Name: shift_ctrl

Overview:
Command sequencer for the N-bit shift register datapath. It accepts one command at a time over a valid/ready interface: clear, load, or a multi-bit logical shift right or left. It expands each command into per-cycle ctrl codes for the shift register, captures the register's result, and returns it over a valid/ready response interface. The block sits between a host or bus-side requester and the shift register, and is the only driver of the register's ctrl and in ports.

Parameters:
N, 8, data width; must match the controlled shift register (N >= 2)
AW, 4, width of cmd_amt (shift amount field)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  2  0=clear, 1=load, 2=shift right, 3=shift left
cmd_amt  input  AW  shift distance (ignored for clear/load)
cmd_data  input  N  load value (ignored unless op=1)
sr_ctrl  output  3  to shift register ctrl: 0 clear, 1 load, 2 shr1, 3 shl1, 4 hold
sr_in  output  N  to shift register in
sr_out  input  N  from shift register out
rsp_valid  output  1  result available
rsp_ready  input  1  requester takes result
rsp_data  output  N  register contents after the command
busy  output  1  high in every state except IDLE

Behaviour:
- FSM states: IDLE, EXEC, CAPT, RESP. All outputs are registered or decoded from registered state only (Moore); no combinational path from any input to any output.
- Reset (async, any state): state=IDLE, sr_ctrl=4 (hold), sr_in=0, rsp_valid=0, rsp_data=0, step counter=0, busy=0, cmd_ready=1 once rst deasserts. A reset mid-command abandons it; no response is produced. Shift register contents are not restored.
- cmd_ready=1 only in IDLE. A command is accepted on a rising edge where cmd_valid && cmd_ready. On acceptance: latch op; load sr_in<=cmd_data if op=1, otherwise sr_in keeps its value; compute steps.
- steps: 1 for clear or load. For shifts, steps=min(cmd_amt, N); cmd_amt >= N performs exactly N single-bit shifts (result 0).
- IDLE -> EXEC when steps>0. IDLE -> CAPT directly for a shift with cmd_amt=0 (no register update; current contents are returned).
- EXEC: sr_ctrl=op code (0/1/2/3) for exactly `steps` consecutive cycles; counter decrements each cycle; on last step -> CAPT.
- CAPT: one cycle, sr_ctrl=4; sr_out now reflects the final value; rsp_data<=sr_out at end of cycle; -> RESP with rsp_valid=1.
- RESP: rsp_valid and rsp_data held stable until rsp_ready sampled high; then rsp_valid=0 and -> IDLE. rsp_ready outside RESP is ignored.
- sr_ctrl=4 in IDLE, CAPT, RESP. Codes 5-7 are never driven.
- Latency: acceptance at edge E -> rsp_valid rises at edge E+steps+1 (load: E+2; shift by 3: E+4; shift by 0: E+1).
- Throughput: one command in flight; next acceptance no earlier than the edge after the rsp handshake (IDLE re-entered).
- cmd_valid may be asserted while busy; the command waits and is accepted in the first IDLE cycle with no loss or reorder.

Test Plan:
- Reset then load 8'hA5 -> sr_ctrl=1 for exactly 1 cycle; rsp_valid 2 cycles after accept edge; rsp_data=8'hA5.
- Load 8'hA5, shift right amt=3 -> sr_ctrl=2 for 3 cycles; rsp_data=8'h14. Shift left amt=2 -> rsp_data=8'h50.
- Load 8'hFF, shift left amt=15 (>=N) -> exactly 8 cycles of sr_ctrl=3; rsp_data=8'h00.
- Load 8'h3C, shift right amt=0 -> no non-hold sr_ctrl cycle; rsp_valid at accept edge+1; rsp_data=8'h3C. Clear -> rsp_data=8'h00.
- Hold rsp_ready=0 for 5 cycles in RESP with cmd_valid=1 -> rsp_valid/rsp_data stable, cmd_ready=0; after rsp_ready pulse, queued command accepted next cycle.
- Assert rst during EXEC of shift amt=6 -> immediately sr_ctrl=4, rsp_valid=0, busy=0; no response emitted; next load 8'h81 completes normally.
